life_cell_gen: RTL and testbench

//  Parametrised Game-of-Life cell for the cellular-automaton array. Successor to the fixed B3/S23 cell.

---
 rtl/life_cell_gen.sv | 84 ++++++++
 tb/tb_life_cell_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/life_cell_gen.sv
// life_cell_gen: parametrised Game-of-Life cell with programmable rule, Generations decay, age and change flag
// Optional feature macro: LIFE_CELL_RULE_REG_EN (rule registers loadable via rule_we; otherwise rules are constants)
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   step, set, clear      advance one generation / force alive / force dead (clear > set > step)
//   neighbors             live flags of neighbour cells
//   rule_we, rule_birth, rule_survive   rule register load
//   alive, notalive       registered state==1 and its complement
//   state                 current cell state
//   age                   saturating count of consecutive generations survived
//   changed               state changed on the previous edge
module life_cell_gen #(
   parameter int NEIGHBORS = 8,
   parameter int NUM_STATES = 2,
   parameter int AGE_W = 8,
   parameter logic [NEIGHBORS:0] RESET_BIRTH = 9'b000001000,
   parameter logic [NEIGHBORS:0] RESET_SURVIVE = 9'b000001100,
   localparam int SW = NUM_STATES > 2 ? $clog2(NUM_STATES) : 1,
   localparam int CW = $clog2(NEIGHBORS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 step,
   input  logic                 set,
   input  logic                 clear,
   input  logic [NEIGHBORS-1:0] neighbors,
   input  logic                 rule_we,
   input  logic [NEIGHBORS:0]   rule_birth,
   input  logic [NEIGHBORS:0]   rule_survive,
   output logic                 alive,
   output logic                 notalive,
   output logic [SW-1:0]        state,
   output logic [AGE_W-1:0]     age,
   output logic                 changed
);
   logic [NEIGHBORS:0] birth, survive;
   logic [CW-1:0]      count;
   logic [SW-1:0]      step_state, nxt_state;
   logic [AGE_W-1:0]   nxt_age;
   logic               survived;
`ifdef LIFE_CELL_RULE_REG_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         birth <= RESET_BIRTH;
         survive <= RESET_SURVIVE;
      end else if (rule_we) begin
         birth <= rule_birth;
         survive <= rule_survive;
      end
`else
   logic unused_rule;
   assign unused_rule = ^{rule_we, rule_birth, rule_survive};
   assign birth = RESET_BIRTH;
   assign survive = RESET_SURVIVE;
`endif
   always_comb begin
      count = '0;
      for (int i = 0; i < NEIGHBORS; i++) count = count + CW'(neighbors[i]);
   end
   // States >= 2 are decay states: they ignore neighbours and walk towards 0.
   always_comb begin
      step_state = state == '0 ? (birth[count] ? SW'(1) : '0) :
                   state == SW'(1) ? (survive[count] ? SW'(1) : (NUM_STATES == 2 ? '0 : SW'(2))) :
                   state == SW'(NUM_STATES - 1) ? '0 : state + SW'(1);
      nxt_state = clear ? '0 : set ? SW'(1) : step ? step_state : state;
      survived = !clear && !set && step && state == SW'(1) && step_state == SW'(1);
      nxt_age = !(clear || set || step) ? age :
                survived ? (&age ? age : age + AGE_W'(1)) : '0;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= '0;
         alive <= 1'b0;
         notalive <= 1'b1;
         age <= '0;
         changed <= 1'b0;
      end else begin
         state <= nxt_state;
         alive <= nxt_state == SW'(1);
         notalive <= nxt_state != SW'(1);
         age <= nxt_age;
         changed <= nxt_state != state;
      end
endmodule

// File: tb/tb_life_cell_gen.sv
// tb_life_cell_gen: directed self-checking bench for life_cell_gen (classic and 4-state/2-bit-age builds)
module tb_life_cell_gen;
   logic clk = 1'b0;
   logic reset;
   logic step_a, set_a, clear_a, rule_we_a;
   logic [7:0] nb_a;
   logic [8:0] rb_a, rs_a;
   logic alive_a, notalive_a, changed_a;
   logic [0:0] state_a;
   logic [7:0] age_a;
   logic step_b, set_b, clear_b, rule_we_b;
   logic [7:0] nb_b;
   logic [8:0] rb_b, rs_b;
   logic alive_b, notalive_b, changed_b;
   logic [1:0] state_b;
   logic [1:0] age_b;
   int n_cmp = 0;
   int n_bad = 0;
   logic b2_alive;

   always #5 clk = ~clk;

   life_cell_gen dut_a (
      .clk(clk), .reset(reset), .step(step_a), .set(set_a), .clear(clear_a),
      .neighbors(nb_a), .rule_we(rule_we_a), .rule_birth(rb_a), .rule_survive(rs_a),
      .alive(alive_a), .notalive(notalive_a), .state(state_a), .age(age_a), .changed(changed_a)
   );

   life_cell_gen #(.NUM_STATES(4), .AGE_W(2)) dut_b (
      .clk(clk), .reset(reset), .step(step_b), .set(set_b), .clear(clear_b),
      .neighbors(nb_b), .rule_we(rule_we_b), .rule_birth(rb_b), .rule_survive(rs_b),
      .alive(alive_b), .notalive(notalive_b), .state(state_b), .age(age_b), .changed(changed_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic s, input logic [7:0] ag, input logic ch);
      check({tag, ".state"}, 32'(state_a), 32'(s));
      check({tag, ".alive"}, 32'(alive_a), 32'(s));
      check({tag, ".notalive"}, 32'(notalive_a), 32'(!s));
      check({tag, ".age"}, 32'(age_a), 32'(ag));
      check({tag, ".changed"}, 32'(changed_a), 32'(ch));
   endtask

   task automatic chk_b(input string tag, input logic [1:0] s, input logic [1:0] ag, input logic ch);
      check({tag, ".state"}, 32'(state_b), 32'(s));
      check({tag, ".alive"}, 32'(alive_b), 32'(s == 2'd1));
      check({tag, ".age"}, 32'(age_b), 32'(ag));
      check({tag, ".changed"}, 32'(changed_b), 32'(ch));
   endtask

   initial begin
`ifdef LIFE_CELL_RULE_REG_EN
      b2_alive = 1'b1;
`else
      b2_alive = 1'b0;
`endif
      reset = 1'b1;
      {step_a, set_a, clear_a, rule_we_a} = 4'b1100;
      nb_a = 8'h07; rb_a = 9'b000001000; rs_a = 9'b000001100;
      {step_b, set_b, clear_b, rule_we_b} = 4'b1100;
      nb_b = 8'h00; rb_b = 9'b000001000; rs_b = 9'b000001100;
      tick(); tick();
      chk_a("rst", 1'b0, 8'd0, 1'b0);
      chk_b("rst_b", 2'd0, 2'd0, 1'b0);
      {step_a, set_a} = 2'b00;
      {step_b, set_b} = 2'b00;
      reset = 1'b0;
      tick();
      chk_a("rst_rel", 1'b0, 8'd0, 1'b0);
      // birth with 3 neighbours
      nb_a = 8'b00000111; step_a = 1'b1;
      tick();
      chk_a("birth", 1'b1, 8'd0, 1'b1);
      step_a = 1'b0;
      tick();
      chk_a("birth_hold", 1'b1, 8'd0, 1'b0);
      nb_a = 8'b00000011; step_a = 1'b1;
      tick(); tick(); tick();
      chk_a("survive3", 1'b1, 8'd3, 1'b0);
      step_a = 1'b0;
      tick();
      chk_a("age_hold", 1'b1, 8'd3, 1'b0);
      // underpopulation
      nb_a = 8'b00000001; step_a = 1'b1;
      tick();
      chk_a("death", 1'b0, 8'd0, 1'b1);
      {set_a, clear_a} = 2'b11;
      tick();
      chk_a("clr_win0", 1'b0, 8'd0, 1'b0);
      {set_a, clear_a} = 2'b10; step_a = 1'b0;
      tick();
      chk_a("set", 1'b1, 8'd0, 1'b1);
      nb_a = 8'b00000011; {set_a, clear_a, step_a} = 3'b111;
      tick();
      chk_a("clr_win1", 1'b0, 8'd0, 1'b1);
      // count 8 boundary: no birth under B3 or B2
      nb_a = 8'hFF; {set_a, clear_a, step_a} = 3'b001;
      tick();
      chk_a("count8", 1'b0, 8'd0, 1'b0);
      // rule load: same-edge step uses old B3 mask
      nb_a = 8'b00000011; rule_we_a = 1'b1; rb_a = 9'b000000100;
      tick();
      chk_a("rule_old", 1'b0, 8'd0, 1'b0);
      rule_we_a = 1'b0;
      tick();
      chk_a("rule_new", b2_alive, 8'd0, b2_alive);
      // reset returns rules to B3: count 2 must not give birth afterwards
      reset = 1'b1; step_a = 1'b0;
      tick();
      reset = 1'b0;
      chk_a("rst_mid", 1'b0, 8'd0, 1'b0);
      step_a = 1'b1;
      tick();
      chk_a("rule_rst", 1'b0, 8'd0, 1'b0);
      step_a = 1'b0;
      // Generations decay on 4-state cell
      set_b = 1'b1;
      tick();
      chk_b("b_set", 2'd1, 2'd0, 1'b1);
      set_b = 1'b0; nb_b = 8'h00; step_b = 1'b1;
      tick();
      chk_b("decay2", 2'd2, 2'd0, 1'b1);
      nb_b = 8'h07;
      tick();
      chk_b("decay3", 2'd3, 2'd0, 1'b1);
      tick();
      chk_b("decay0", 2'd0, 2'd0, 1'b1);
      nb_b = 8'h00;
      tick();
      chk_b("decay00", 2'd0, 2'd0, 1'b0);
      // age saturation at 2 bits
      step_b = 1'b0; set_b = 1'b1;
      tick();
      chk_b("b_set2", 2'd1, 2'd0, 1'b1);
      set_b = 1'b0; nb_b = 8'h03; step_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_b($sformatf("age%0d", i + 1), 2'd1, (i < 3) ? 2'(i + 1) : 2'd3, 1'b0);
      end
      set_b = 1'b1;
      tick();
      chk_b("set_alive", 2'd1, 2'd0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
